// File: rtl/host_link_ctrl.sv
// -----------------------------------------------------------------------------
// host_link_ctrl
//   CPU<->FPGA link controller for the move generator.
//   Receives one board packet from the CPU->FPGA FIFO. The packet is PW piece
//   words (PPW pieces per word, LSB first) followed by one meta word. The meta
//   word carries enp[15:0], castle[19:16] and turn[DATA_W-1]. The controller
//   presents a stable board image, pulses board_load and then gen_start. It
//   streams the generator's moves into the FPGA->CPU FIFO under tx_full
//   backpressure. It closes the list with an end-of-list word
//   {move_count, 16'hFFFF} and raises irq for IRQ_CYCLES cycles.
//
//   Optional feature macro: HOST_LINK_CHECKSUM_EN
//     With the macro defined, the packet carries one extra final word. That
//     word is the XOR of all preceding words. A bad packet leaves the board
//     untouched and sets the sticky err output. The controller then answers
//     with {0, 16'hFFFE} and an irq. Without the macro, err is tied to 0.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rx_empty, rx_dav, rx_data   CPU->FPGA FIFO status / data-valid / word
//   tx_full, tx_wr, tx_wdata    FPGA->CPU FIFO full / write strobe / word
//   irq                      CPU interrupt
//   board                    square s at [s*PIECE_W +: PIECE_W]
//   turn, enp_flags, castle_flags   meta fields of the current board
//   board_load, gen_start    single-cycle pulses towards the generator
//   gen_done                 generator finished (level or pulse)
//   mv_valid, mv_data, mv_ready  move handshake from the generator
//   err                      sticky checksum error
// -----------------------------------------------------------------------------
module host_link_ctrl #(
    parameter int DATA_W     = 32,
    parameter int PIECE_W    = 10,
    parameter int SQUARES    = 64,
    parameter int MOVE_W     = 16,
    parameter int IRQ_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_empty,
    input  logic                       rx_dav,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       tx_full,
    output logic                       tx_wr,
    output logic [DATA_W-1:0]          tx_wdata,
    output logic                       irq,
    output logic [SQUARES*PIECE_W-1:0] board,
    output logic                       turn,
    output logic [15:0]                enp_flags,
    output logic [3:0]                 castle_flags,
    output logic                       board_load,
    output logic                       gen_start,
    input  logic                       gen_done,
    input  logic                       mv_valid,
    input  logic [MOVE_W-1:0]          mv_data,
    output logic                       mv_ready,
    output logic                       err
);

    localparam int PPW = DATA_W / PIECE_W;
    localparam int PW  = (SQUARES + PPW - 1) / PPW;
`ifdef HOST_LINK_CHECKSUM_EN
    localparam int N_WORDS = PW + 2;
`else
    localparam int N_WORDS = PW + 1;
`endif
    localparam int CNT_W = $clog2(N_WORDS + 1);
    localparam int MC_W  = DATA_W - 16;
    localparam int IRQ_W = $clog2(IRQ_CYCLES + 1);

    localparam logic [CNT_W-1:0] META_IDX = CNT_W'(PW);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RCV,
        S_LOAD,
        S_GEN,
        S_EOP,
        S_IRQ
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]           word_cnt_q;
    logic [SQUARES*PIECE_W-1:0] stage_q;
    logic                       stage_turn_q;
    logic [15:0]                stage_enp_q;
    logic [3:0]                 stage_castle_q;
    logic [SQUARES*PIECE_W-1:0] board_q;
    logic                       turn_q;
    logic [15:0]                enp_q;
    logic [3:0]                 castle_q;
    logic [MC_W-1:0]            mv_cnt_q;
    logic                       done_q;
    logic                       first_q;
    logic [IRQ_W-1:0]           irq_cnt_q;

    // Strobes decoded by the FSM, consumed by the datapath.
    logic word_acc;   // a packet word is accepted this cycle
    logic last_acc;   // ... and it is the final word of the packet
    logic pkt_ok;     // final word accepted and packet is good: publish board
    logic mv_acc;     // a move is transferred to the tx FIFO this cycle
    logic irq_end;    // last interrupt cycle
    logic csum_ok;
    logic meta_hit;
    logic [15:0] eop_tag;

    // Pad slots of the last piece word and the meta bits between castle and
    // turn carry no information.
    logic rx_unused;
    assign rx_unused = ^rx_data;

    assign meta_hit = (word_cnt_q == META_IDX);

`ifdef HOST_LINK_CHECKSUM_EN
    logic [DATA_W-1:0] xor_q;
    logic              err_q;
    // xor_q holds the XOR of every word before the current one. At the
    // final word, that value is exactly what the checksum must equal.
    assign csum_ok = (rx_data == xor_q);
    assign err     = err_q;
    // err_q is already set when a bad packet reaches EOP. A good packet has
    // cleared it on its way into LOAD.
    assign eop_tag = err_q ? 16'hFFFE : 16'hFFFF;
`else
    assign csum_ok = 1'b1;
    assign err     = 1'b0;
    assign eop_tag = 16'hFFFF;
`endif

    // -------------------------------------------------------------------------
    // FSM: next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. Any path that
        // forgets an assignment would otherwise infer a latch.
        state_d    = state_q;
        tx_wr      = 1'b0;
        tx_wdata   = '0;
        mv_ready   = 1'b0;
        board_load = 1'b0;
        gen_start  = 1'b0;
        irq        = 1'b0;
        word_acc   = 1'b0;
        last_acc   = 1'b0;
        pkt_ok     = 1'b0;
        mv_acc     = 1'b0;
        irq_end    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_empty) state_d = S_RCV;
            end
            S_RCV: begin
                if (rx_dav) begin
                    word_acc = 1'b1;
                    if (word_cnt_q == LAST_IDX) begin
                        last_acc = 1'b1;
                        if (csum_ok) begin
                            pkt_ok  = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_EOP;
                        end
                    end
                end
            end
            S_LOAD: begin
                board_load = 1'b1;
                state_d    = S_GEN;
            end
            S_GEN: begin
                gen_start = first_q;
                mv_ready  = !tx_full;
                if (mv_valid && !tx_full) begin
                    mv_acc   = 1'b1;
                    tx_wr    = 1'b1;
                    tx_wdata = DATA_W'(mv_data);
                end
                // A move offered together with gen_done is still taken. The
                // exit waits until no move is pending.
                if (done_q && !mv_valid) state_d = S_EOP;
            end
            S_EOP: begin
                tx_wr    = !tx_full;
                tx_wdata = {mv_cnt_q, eop_tag};
                if (!tx_full) state_d = S_IRQ;
            end
            S_IRQ: begin
                irq = 1'b1;
                if (irq_cnt_q == IRQ_W'(IRQ_CYCLES - 1)) begin
                    irq_end = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: staging registers are flops rather than RAM, so they are reset
    // along with everything else. A packet cut short by reset therefore
    // leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            word_cnt_q     <= '0;
            stage_q        <= '0;
            stage_turn_q   <= 1'b0;
            stage_enp_q    <= '0;
            stage_castle_q <= '0;
            board_q        <= '0;
            turn_q         <= 1'b0;
            enp_q          <= '0;
            castle_q       <= '0;
            mv_cnt_q       <= '0;
            done_q         <= 1'b0;
            first_q        <= 1'b0;
            irq_cnt_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only, so
            // every register samples pre-edge values no matter the order of
            // statements.
            state_q <= state_d;

            if (word_acc) begin
                word_cnt_q <= last_acc ? '0 : word_cnt_q + CNT_W'(1);
                // Square s lives in word s/PPW, slot s%PPW. Unused slots of
                // the last piece word map to no square.
                for (int s = 0; s < SQUARES; s++) begin
                    if (word_cnt_q == CNT_W'(s / PPW))
                        stage_q[s*PIECE_W +: PIECE_W] <= rx_data[(s % PPW)*PIECE_W +: PIECE_W];
                end
                if (meta_hit) begin
                    stage_enp_q    <= rx_data[15:0];
                    stage_castle_q <= rx_data[19:16];
                    stage_turn_q   <= rx_data[DATA_W-1];
                end
            end

            // The meta word is the final word unless a checksum follows it.
            // In that case the meta fields are taken straight from the bus.
            if (pkt_ok) begin
                board_q  <= stage_q;
                enp_q    <= meta_hit ? rx_data[15:0]      : stage_enp_q;
                castle_q <= meta_hit ? rx_data[19:16]     : stage_castle_q;
                turn_q   <= meta_hit ? rx_data[DATA_W-1]  : stage_turn_q;
            end

            if (state_q == S_LOAD)     first_q <= 1'b1;
            else if (state_q == S_GEN) first_q <= 1'b0;

            if (state_q == S_GEN && gen_done) done_q <= 1'b1;

            if (mv_acc && mv_cnt_q != '1) mv_cnt_q <= mv_cnt_q + MC_W'(1);

            if (state_q == S_IRQ) irq_cnt_q <= irq_cnt_q + IRQ_W'(1);

            if (irq_end) begin
                irq_cnt_q <= '0;
                mv_cnt_q  <= '0;
                done_q    <= 1'b0;
            end
        end
    end

`ifdef HOST_LINK_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (word_acc) xor_q <= last_acc ? '0 : (xor_q ^ rx_data);
            if (last_acc && !csum_ok) err_q <= 1'b1;
            else if (pkt_ok)          err_q <= 1'b0;
        end
    end
`endif

    assign board        = board_q;
    assign turn         = turn_q;
    assign enp_flags    = enp_q;
    assign castle_flags = castle_q;

endmodule

// File: tb/tb_host_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_host_link_ctrl
//   Directed bench for host_link_ctrl. Inputs change 1 ns after the rising
//   edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_host_link_ctrl;

    localparam int DATA_W     = 32;
    localparam int PIECE_W    = 10;
    localparam int SQUARES    = 64;
    localparam int MOVE_W     = 16;
    localparam int IRQ_CYCLES = 4;
    localparam int PW         = 22;
`ifdef HOST_LINK_CHECKSUM_EN
    localparam int N_WORDS = PW + 2;
`else
    localparam int N_WORDS = PW + 1;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       rx_empty, rx_dav;
    logic [DATA_W-1:0]          rx_data;
    logic                       tx_full, tx_wr;
    logic [DATA_W-1:0]          tx_wdata;
    logic                       irq;
    logic [SQUARES*PIECE_W-1:0] board;
    logic                       turn;
    logic [15:0]                enp_flags;
    logic [3:0]                 castle_flags;
    logic                       board_load, gen_start, gen_done;
    logic                       mv_valid, mv_ready, err;
    logic [MOVE_W-1:0]          mv_data;

    host_link_ctrl #(
        .DATA_W(DATA_W), .PIECE_W(PIECE_W), .SQUARES(SQUARES),
        .MOVE_W(MOVE_W), .IRQ_CYCLES(IRQ_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty), .rx_dav(rx_dav), .rx_data(rx_data),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
        .irq(irq), .board(board), .turn(turn),
        .enp_flags(enp_flags), .castle_flags(castle_flags),
        .board_load(board_load), .gen_start(gen_start), .gen_done(gen_done),
        .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int tx_full_viol = 0;
    logic [31:0] txq[$];
    logic [31:0] expq[$];

    typedef struct {
        logic [9:0]       base;
        logic             turn;
        logic [3:0]       castle;
        logic [15:0]      enp;
        int               n;
        logic [2:0][15:0] mv;
        bit               same_cycle;
        int               stall_at;
        logic [9:0]       exp_sq0;
        logic [9:0]       exp_sq32;
        logic [9:0]       exp_sq63;
        logic [31:0]      exp_eop;
    } vec_t;

    vec_t vecs[3];

    // Record every word the DUT writes. Also flag writes into a full FIFO.
    always @(negedge clk) begin
        if (!rst && tx_wr) begin
            if (tx_full) tx_full_viol++;
            txq.push_back(tx_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] sq(input int s);
        return board[s*PIECE_W +: PIECE_W];
    endfunction

    // Piece s is base+s. Unused slots and the two top bits carry junk that
    // the DUT must ignore.
    function automatic logic [31:0] piece_word(input logic [9:0] base, input int w);
        logic [31:0] r;
        r = 32'hC000_0000;
        for (int j = 0; j < 3; j++) begin
            if (3*w + j < SQUARES) r[j*10 +: 10] = base + 10'(3*w + j);
            else                   r[j*10 +: 10] = 10'h2AA;
        end
        return r;
    endfunction

    // Sends a packet. The task starts with a junk rx_dav in IDLE, which the
    // DUT must drop, and leaves a one-cycle gap after word 5. With stop_after
    // >= 0, the task returns after that many words while the DUT is mid-packet.
    task automatic send_packet(input logic [9:0] base, input logic [31:0] meta,
                               input int stop_after, input bit bad_csum);
        logic [31:0] w, x;
        x = '0;
        rx_dav = 1'b1; rx_data = 32'hDEAD_BEEF;
        step();
        rx_dav = 1'b0; rx_empty = 1'b0;
        step();
        for (int i = 0; i < N_WORDS; i++) begin
            if (i == stop_after) begin
                rx_dav = 1'b0;
                return;
            end
            if (i < PW)       w = piece_word(base, i);
            else if (i == PW) w = meta;
            else              w = bad_csum ? (x ^ 32'h1) : x;
            x = x ^ w;
            if (i == 5) begin
                rx_dav = 1'b0;
                step();
            end
            rx_dav = 1'b1; rx_data = w;
            step();
        end
        rx_dav = 1'b0; rx_empty = 1'b1;
    endtask

    // Offers n moves. At index stall_at, tx_full is held high for 5 cycles
    // with the move pending. When same_cycle is set, gen_done comes with the
    // last move. Otherwise gen_done is pulsed after the stream.
    task automatic gen_moves(input logic [2:0][15:0] mv, input int n,
                             input bit same_cycle, input int stall_at);
        for (int i = 0; i < n; i++) begin
            mv_valid = 1'b1; mv_data = mv[i];
            gen_done = same_cycle && (i == n - 1);
            if (i == stall_at) begin
                tx_full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_mv_ready", mv_ready, 0);
                    check("stall_tx_wr", tx_wr, 0);
                    step();
                end
                tx_full = 1'b0;
            end
            @(negedge clk);
            check("mv_ready", mv_ready, 1);
            step();
        end
        mv_valid = 1'b0;
        if (!same_cycle || n == 0) begin
            gen_done = 1'b1;
            step();
        end
        gen_done = 1'b0;
    endtask

    // Waits for irq, checks its length, and compares the recorded tx words
    // with expq.
    task automatic wait_done(input string tag);
        int t, len;
        t = 0;
        @(negedge clk);
        while (irq !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s_irq_seen", tag), irq, 1);
        len = 0;
        while (irq === 1'b1 && len < 50) begin
            len++;
            @(negedge clk);
        end
        check($sformatf("%s_irq_len", tag), len, IRQ_CYCLES);
        check($sformatf("%s_tx_count", tag), txq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            check($sformatf("%s_tx_word%0d", tag, i),
                  (i < txq.size()) ? txq[i] : 32'hxxxx_xxxx, expq[i]);
        step();
    endtask

    // Checks load and start timing, then the published board image.
    task automatic check_load(input string tag, input logic [9:0] s0, input logic [9:0] s32,
                              input logic [9:0] s63, input logic t, input logic [3:0] c,
                              input logic [15:0] e);
        @(negedge clk);
        check($sformatf("%s_board_load_T1", tag), board_load, 1);
        check($sformatf("%s_gen_start_T1", tag), gen_start, 0);
        check($sformatf("%s_sq0", tag), sq(0), s0);
        check($sformatf("%s_sq32", tag), sq(32), s32);
        check($sformatf("%s_sq63", tag), sq(63), s63);
        check($sformatf("%s_turn", tag), turn, t);
        check($sformatf("%s_castle", tag), castle_flags, c);
        check($sformatf("%s_enp", tag), enp_flags, e);
        step();
        @(negedge clk);
        check($sformatf("%s_board_load_T2", tag), board_load, 0);
        check($sformatf("%s_gen_start_T2", tag), gen_start, 1);
        step();
        @(negedge clk);
        check($sformatf("%s_gen_start_T3", tag), gen_start, 0);
        step();
    endtask

    initial begin
        vecs[0] = '{base: 10'h000, turn: 1'b1, castle: 4'hA, enp: 16'h0101,
                    n: 2, mv: {16'h0000, 16'h0ABC, 16'h1234}, same_cycle: 1'b0, stall_at: -1,
                    exp_sq0: 10'h000, exp_sq32: 10'h020, exp_sq63: 10'h03F,
                    exp_eop: 32'h0002_FFFF};
        vecs[1] = '{base: 10'h3C0, turn: 1'b0, castle: 4'h5, enp: 16'h8000,
                    n: 0, mv: {16'h0000, 16'h0000, 16'h0000}, same_cycle: 1'b0, stall_at: -1,
                    exp_sq0: 10'h3C0, exp_sq32: 10'h3E0, exp_sq63: 10'h3FF,
                    exp_eop: 32'h0000_FFFF};
        vecs[2] = '{base: 10'h3F0, turn: 1'b1, castle: 4'hF, enp: 16'hFFFF,
                    n: 3, mv: {16'h8000, 16'h0001, 16'hFFFF}, same_cycle: 1'b1, stall_at: 1,
                    exp_sq0: 10'h3F0, exp_sq32: 10'h010, exp_sq63: 10'h02F,
                    exp_eop: 32'h0003_FFFF};

        rst = 1'b1; rx_empty = 1'b1; rx_dav = 1'b0; rx_data = '0;
        tx_full = 1'b0; gen_done = 1'b0; mv_valid = 1'b0; mv_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_irq", irq, 0);
        check("rst_board_load", board_load, 0);
        check("rst_gen_start", gen_start, 0);
        check("rst_mv_ready", mv_ready, 0);
        check("rst_err", err, 0);
        check("rst_board_zero", board == '0, 1);
        check("rst_flags", {turn, castle_flags, enp_flags}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Table-driven packets: load timing, board image, move streaming.
        for (int v = 0; v < 3; v++) begin
            txq.delete();
            expq.delete();
            for (int i = 0; i < vecs[v].n; i++) expq.push_back({16'h0000, vecs[v].mv[i]});
            expq.push_back(vecs[v].exp_eop);
            send_packet(vecs[v].base, {vecs[v].turn, 11'h5A5, vecs[v].castle, vecs[v].enp}, -1, 1'b0);
            check_load($sformatf("vec%0d", v), vecs[v].exp_sq0, vecs[v].exp_sq32,
                       vecs[v].exp_sq63, vecs[v].turn, vecs[v].castle, vecs[v].enp);
            gen_moves(vecs[v].mv, vecs[v].n, vecs[v].same_cycle, vecs[v].stall_at);
            wait_done($sformatf("vec%0d", v));
            @(negedge clk);
            check($sformatf("vec%0d_hold_sq63", v), sq(63), vecs[v].exp_sq63);
            step();
        end

        // Reset after 10 words of a packet.
        send_packet(10'h100, {1'b1, 11'h0, 4'h1, 16'h1111}, 10, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_board_zero", board == '0, 1);
        check("midrst_flags", {turn, castle_flags, enp_flags}, 0);
        check("midrst_tx_wr", tx_wr, 0);
        check("midrst_irq", irq, 0);
        rx_empty = 1'b1;
        step();
        rst = 1'b0;
        step();
        txq.delete();
        expq.delete();
        expq.push_back(32'h0000_00AA);
        expq.push_back(32'h0001_FFFF);
        send_packet(10'h055, {1'b0, 11'h7FF, 4'h3, 16'h0040}, -1, 1'b0);
        check_load("fresh", 10'h055, 10'h075, 10'h094, 1'b0, 4'h3, 16'h0040);
        gen_moves({16'h0000, 16'h0000, 16'h00AA}, 1, 1'b0, -1);
        wait_done("fresh");

`ifdef HOST_LINK_CHECKSUM_EN
        // Corrupt checksum: no load, sticky err, 0xFFFE end word.
        txq.delete();
        expq.delete();
        expq.push_back(32'h0000_FFFE);
        send_packet(10'h111, {1'b1, 11'h0, 4'h2, 16'h0202}, -1, 1'b1);
        @(negedge clk);
        check("bad_board_load", board_load, 0);
        check("bad_gen_start", gen_start, 0);
        check("bad_err", err, 1);
        check("bad_sq0_kept", sq(0), 10'h055);
        step();
        wait_done("bad");
        @(negedge clk);
        check("bad_err_sticky", err, 1);
        step();
        // A good packet clears err by the LOAD cycle.
        txq.delete();
        expq.delete();
        expq.push_back(32'h0000_FFFF);
        send_packet(10'h000, {1'b1, 11'h0, 4'hA, 16'h0101}, -1, 1'b0);
        @(negedge clk);
        check("good_err_at_load", err, 0);
        check_load("good", 10'h000, 10'h020, 10'h03F, 1'b1, 4'hA, 16'h0101);
        gen_moves({16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, -1);
        wait_done("good");
`endif

        check("tx_wr_while_full", tx_full_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
